// File: rtl/bram_ctrl.sv
// bram_ctrl: banked byte-lane BRAM controller behind a req/rdy/ack port.
//   clk, rst_n          clock, async active-low reset
//   req, wr, size, sext request, direction, 00 byte / 01 half / 10 word, sign-extend reads
//   adr, wdata          byte address, right-aligned write data
//   rdy, ack, err       can accept, one-cycle completion, rejected access (valid with ack)
//   rdata               right-aligned read data, held until the next ack
module bram_ctrl #(
    parameter int BANK_AW   = 15,
    parameter int NUM_BANKS = 4,
    parameter int ADR_W     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             wr,
    input  logic [1:0]       size,
    input  logic             sext,
    input  logic [ADR_W-1:0] adr,
    input  logic [31:0]      wdata,
    output logic             rdy,
    output logic             ack,
    output logic             err,
    output logic [31:0]      rdata
);
    localparam int BW = ADR_W - BANK_AW - 2;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state;
    logic ph, wr_q, sext_q, bad, en;
    logic [1:0] size_q;
    logic [ADR_W-1:0] adr_q;
    logic [31:0] wd_q, wd, qs, rd_al;
    logic [15:0] sh;
    logic [3:0] lanes;
    logic [BW-1:0] bsel;
    logic [BANK_AW-1:0] ia;
    logic [NUM_BANKS*32-1:0] q;
    assign bsel  = adr_q[ADR_W-1:BANK_AW+2];
    assign ia    = adr_q[BANK_AW+1:2];
    assign bad   = size_q == 2'b11 || (size_q == 2'b01 && adr_q[0]) ||
                   (size_q == 2'b10 && adr_q[1:0] != 2'b00) || bsel >= BW'(NUM_BANKS);
    // BRAM access happens only on the first ACC cycle; the second cycle aligns the registered output
    assign en    = state == ACC && !ph && !bad;
    assign rdy   = state != ACC;
    assign lanes = size_q == 2'b00 ? 4'b0001 << adr_q[1:0] :
                   size_q == 2'b01 ? (adr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd    = size_q == 2'b00 ? {4{wd_q[7:0]}} : size_q == 2'b01 ? {2{wd_q[15:0]}} : wd_q;
    always_comb begin
        qs = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            if (bsel == BW'(i)) qs = q[32*i+:32];
    end
    assign sh    = size_q == 2'b00 ? 16'(qs >> {adr_q[1:0], 3'b000}) : 16'(qs >> {adr_q[1], 4'b0000});
    assign rd_al = size_q == 2'b00 ? {{24{sext_q & sh[7]}}, sh[7:0]} :
                   size_q == 2'b01 ? {{16{sext_q & sh[15]}}, sh[15:0]} : qs;
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0] mem [2**BANK_AW];
        logic sel;
        logic [3:0] we;
        assign sel = en && bsel == BW'(b);
        assign we  = sel && wr_q ? lanes : 4'b0000;
        always_ff @(posedge clk)
            if (sel) begin
                for (int l = 0; l < 4; l++)
                    if (we[l]) mem[ia][8*l+:8] <= wd[8*l+:8];
                q[32*b+:32] <= mem[ia];
            end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            ph     <= 1'b0;
            wr_q   <= 1'b0;
            sext_q <= 1'b0;
            size_q <= 2'b00;
            adr_q  <= '0;
            wd_q   <= '0;
            ack    <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (state == ACC) begin
                ph <= 1'b1;
                if (ph) begin
                    state <= DONE;
                    ack   <= 1'b1;
                    err   <= bad;
                    rdata <= bad ? '0 : wr_q ? rdata : rd_al;
                end
            end else if (req) begin
                state  <= ACC;
                ph     <= 1'b0;
                wr_q   <= wr;
                sext_q <= sext;
                size_q <= size;
                adr_q  <= adr;
                wd_q   <= wdata;
            end else
                state <= IDLE;
        end
endmodule

// File: tb/tb_bram_ctrl.sv
// tb_bram_ctrl: directed scoreboard bench for bram_ctrl with three 128 KB banks.
module tb_bram_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, wr = 1'b0, sext = 1'b0;
    logic [1:0] size = 2'b00;
    logic [23:0] adr = '0;
    logic [31:0] wdata = '0;
    logic rdy, ack, err;
    logic [31:0] rdata;
    int compared = 0, mismatched = 0;
    typedef struct {logic e; logic [31:0] d;} exp_t;
    exp_t sb[$];
    logic [31:0] last_rd = '0;

    bram_ctrl #(.BANK_AW(15), .NUM_BANKS(3), .ADR_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .sext(sext),
        .adr(adr), .wdata(wdata), .rdy(rdy), .ack(ack), .err(err), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [23:0] a, input logic [31:0] wd, input logic e,
                          input logic [31:0] rd);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, {31'b0, rdy}, 32'd1);
        req = 1'b1; wr = w; size = sz; sext = sx; adr = a; wdata = wd;
        x.e = e;
        x.d = e ? 32'h0 : (w ? last_rd : rd);
        last_rd = x.d;
        sb.push_back(x);
        @(posedge clk);
        #1 req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 6);
        chk({tag, "_lat"}, n, 32'd3);
        x = sb.pop_front();
        chk({tag, "_err"}, {31'b0, err}, {31'b0, x.e});
        chk({tag, "_rd"}, rdata, x.d);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, ack}, 32'd0);
    endtask

    initial begin
        int acc_n, acks, prev;
        logic stop;
        #12;
        chk("rst_rdy", {31'b0, rdy}, 32'd1);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        access("w100",  1, 2'b10, 0, 24'h000100, 32'hDEADBEEF, 0, 32'h0);
        access("r100",  0, 2'b10, 0, 24'h000100, 32'h0, 0, 32'hDEADBEEF);
        access("wb101", 1, 2'b00, 0, 24'h000101, 32'hFFFFFF5A, 0, 32'h0);
        access("r100b", 0, 2'b10, 0, 24'h000100, 32'h0, 0, 32'hDEAD5AEF);
        access("rb101", 0, 2'b00, 1, 24'h000101, 32'h0, 0, 32'h0000005A);
        access("rb103", 0, 2'b00, 1, 24'h000103, 32'h0, 0, 32'hFFFFFFDE);
        access("rh102", 0, 2'b01, 0, 24'h000102, 32'h0, 0, 32'h0000DEAD);
        access("rh101", 0, 2'b01, 0, 24'h000101, 32'h0, 1, 32'h0);
        access("r100c", 0, 2'b10, 0, 24'h000100, 32'h0, 0, 32'hDEAD5AEF);
        access("rsz3",  0, 2'b11, 0, 24'h000100, 32'h0, 1, 32'h0);
        access("rw102", 0, 2'b10, 0, 24'h000102, 32'h0, 1, 32'h0);

        access("wb0lo", 1, 2'b10, 0, 24'h000000, 32'h33333333, 0, 32'h0);
        access("wb0hi", 1, 2'b10, 0, 24'h01FFFC, 32'h44444444, 0, 32'h0);
        access("woor",  1, 2'b10, 0, 24'h060000, 32'h55555555, 1, 32'h0);
        access("wb2",   1, 2'b10, 0, 24'h05FFFC, 32'h22222222, 0, 32'h0);
        access("wb1",   1, 2'b10, 0, 24'h020000, 32'h11111111, 0, 32'h0);
        access("rb2",   0, 2'b10, 0, 24'h05FFFC, 32'h0, 0, 32'h22222222);
        access("rb1",   0, 2'b10, 0, 24'h020000, 32'h0, 0, 32'h11111111);
        access("rb0lo", 0, 2'b10, 0, 24'h000000, 32'h0, 0, 32'h33333333);
        access("rb0hi", 0, 2'b10, 0, 24'h01FFFC, 32'h0, 0, 32'h44444444);

        access("wh102", 1, 2'b01, 1, 24'h000102, 32'hFFFF1234, 0, 32'h0);
        access("r100d", 0, 2'b10, 0, 24'h000100, 32'h0, 0, 32'h12345AEF);
        access("rb103z",0, 2'b00, 0, 24'h000103, 32'h0, 0, 32'h00000012);
        access("rh100s",0, 2'b01, 1, 24'h000100, 32'h0, 0, 32'h00005AEF);

        access("w200", 1, 2'b10, 0, 24'h000200, 32'h11223344, 0, 32'h0);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; sext = 1'b0; adr = 24'h000200; wdata = 32'hAAAAAAAA;
        @(posedge clk);
        #1 req = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("arst_ack", {31'b0, ack}, 32'd0);
            chk("arst_rdy", {31'b0, rdy}, 32'd1);
            chk("arst_rdata", rdata, 32'd0);
        end
        rst_n = 1'b1;
        last_rd = '0;
        repeat (4) begin
            @(negedge clk);
            chk("arst_noack", {31'b0, ack}, 32'd0);
        end
        access("r200", 0, 2'b10, 0, 24'h000200, 32'h0, 0, 32'h11223344);

        acc_n = 0; acks = 0; prev = -1; stop = 1'b0;
        wr = 1'b0; size = 2'b10; sext = 1'b0; adr = 24'h000100;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                chk("b2b_rd", rdata, 32'h12345AEF);
                chk("b2b_ackrdy", {31'b0, rdy}, 32'd1);
            end
            if (rdy && !stop) begin
                if (prev >= 0) chk("b2b_gap", c - prev, 32'd3);
                prev = c;
                if (acc_n < 10) begin req = 1'b1; acc_n++; end
                else begin req = 1'b0; stop = 1'b1; end
            end
        end
        req = 1'b0;
        chk("b2b_acks", acks, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
